// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate-extension unit with a DEPTH-entry result FIFO.
// Each pushed immediate is extended at push time (sign, zero, upper/LUI, mode 11),
// stored as {err, data}, and presented at the FIFO head through registered outputs.
// Optional feature macro: IMM_EXT_BYTE_MODE_EN
//   defined     -> mode 11 is a byte sign-extend (LB), err bit 0 (needs IN_W >= 8)
//   not defined -> mode 11 is illegal: data 0, err bit 1, entry still queued
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm_in,
   input  logic [1:0]       mode_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] imm_out,
   output logic             err_out,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENT_W = OUT_W + 1;

   // Extension of one immediate into a FIFO entry {err, data}.
   function automatic logic [ENT_W-1:0] ext_fn(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
      logic [ENT_W-1:0] ent;
      case (mode)
         2'b00:   ent = {1'b0, {(OUT_W-IN_W){imm[IN_W-1]}}, imm};
         2'b01:   ent = {1'b0, {(OUT_W-IN_W){1'b0}}, imm};
         2'b10:   ent = {1'b0, imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BYTE_MODE_EN
         2'b11:   ent = {1'b0, {(OUT_W-8){imm[7]}}, imm[7:0]};
`else
         2'b11:   ent = {1'b1, {OUT_W{1'b0}}};
`endif
         default: ent = {ENT_W{1'b0}};
      endcase
      return ent;
   endfunction

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ENT_W-1:0] head_q, head_d;
   logic [ENT_W-1:0] new_entry_s;
   logic             push_s;
   logic             pop_s;

   assign in_ready    = (count_q != CNT_W'(DEPTH));
   assign out_valid   = (count_q != {CNT_W{1'b0}});
   assign push_s      = in_valid && in_ready;
   assign pop_s       = out_valid && out_ready;
   assign new_entry_s = ext_fn(imm_in, mode_in);
   assign imm_out     = head_q[OUT_W-1:0];
   assign err_out     = head_q[OUT_W];
   assign count       = count_q;

   // Next-state for pointers, occupancy and the registered head (holds last pop when empty).
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      head_d  = head_q;
      if (flush) begin
         wr_d    = {PTR_W{1'b0}};
         rd_d    = {PTR_W{1'b0}};
         count_d = {CNT_W{1'b0}};
         head_d  = {ENT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_d = wr_q + PTR_W'(1);
         end else begin
            wr_d = wr_q;
         end
         if (pop_s) begin
            rd_d = rd_q + PTR_W'(1);
         end else begin
            rd_d = rd_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (count_d != {CNT_W{1'b0}}) begin
            // The new head is the incoming entry when nothing older survives this edge.
            if ((count_q == {CNT_W{1'b0}}) || ((count_q == CNT_W'(1)) && pop_s)) begin
               head_d = new_entry_s;
            end else begin
               head_d = mem_q[rd_d];
            end
         end else begin
            head_d = head_q;
         end
      end
   end

   // State registers; async reset discards everything, flush is folded into the _d values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= {PTR_W{1'b0}};
         rd_q    <= {PTR_W{1'b0}};
         count_q <= {CNT_W{1'b0}};
         head_q  <= {ENT_W{1'b0}};
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         head_q  <= head_d;
      end
   end

   // FIFO storage write; a flush cycle drops the push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ENT_W{1'b0}};
         end
      end else if (push_s && !flush) begin
         mem_q[wr_q] <= new_entry_s;
      end
   end

endmodule
